// File: rtl/hack_fetch_pkg.sv
// Shared types and limits for the instruction fetch unit.
// fetch_tag_t tracks one ROM read while it is in flight.
// fetch_entry_t is one returned {address, instruction} pair in the return buffer.
package hack_fetch_pkg;

    localparam int HACK_ADDR_W = 16;
    localparam int HACK_DATA_W = 16;
    localparam int ROM_LAT_MAX = 3;

    typedef struct packed {
        logic                   valid;
        logic [HACK_ADDR_W-1:0] addr;
    } fetch_tag_t;

    typedef struct packed {
        logic [HACK_ADDR_W-1:0] addr;
        logic [HACK_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous return buffer of fetch_entry_t.
// clear_i empties the buffer on the next edge and wins over push/pop.
// Push and pop in the same cycle are both honoured, including when full;
// the parent's credit check guarantees a push into a full buffer only
// happens together with a pop.
module fetch_fifo
    import hack_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     entry_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PC addresses, issues synchronous ROM reads,
// and returns {addr, instruction} pairs in accept order through a return FIFO.
// A request is only accepted when every in-flight read already has a FIFO slot
// reserved, so returning ROM data never has to be dropped (except on flush).
// Optional build macro: FETCH_COUNT_EN adds the saturating fetch_count output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and the offering side holds its payload
// stable while valid is high and ready is low.
module instr_fetch_unit
    import hack_fetch_pkg::*;
#(
    parameter int ADDR_W     = HACK_ADDR_W,
    parameter int DATA_W     = HACK_DATA_W,
    parameter int ROM_LAT    = 1,   // 1..ROM_LAT_MAX
    parameter int FIFO_DEPTH = 4    // power of two, >= ROM_LAT+1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_data,
    input  logic              instr_ready
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int INF_W = $clog2(ROM_LAT + 1);

    fetch_tag_t       tag_q [ROM_LAT];
    fetch_tag_t       tag_d [ROM_LAT];
    logic [INF_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             credit_ok;
    logic             accept;
    logic             push;
    logic             pop;

    // Count reads issued to the ROM whose data has not yet reached the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + INF_W'(tag_q[i].valid);
        end
    end

    // Credit: every in-flight read plus every buffered entry owns one FIFO slot.
    assign occupancy = OCC_W'(inflight) + OCC_W'(fifo_count);
    assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);
    assign req_ready = !rst && !flush && credit_ok;
    assign accept    = req_valid && req_ready;

    // The ROM is strobed in the same cycle the address is accepted.
    assign rom_en   = accept;
    assign rom_addr = req_addr;

    // Tag shift pipe next state: stage 0 captures the accept, later stages shift;
    // flush kills every tag so no stale data is pushed later.
    always_comb begin
        for (int i = 0; i < ROM_LAT; i++) begin
            tag_d[i] = '0;
        end
        tag_d[0].valid = accept;
        tag_d[0].addr  = req_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_d[i]       = tag_q[i-1];
            tag_d[i].valid = tag_q[i-1].valid && !flush;
        end
    end

    // Tag shift pipe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // The last pipe stage lines up with rom_data for that read.
    assign push       = tag_q[ROM_LAT-1].valid && !flush;
    assign push_entry = {tag_q[ROM_LAT-1].addr, rom_data};

    assign instr_valid = !rst && (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr_addr  = fifo_head.addr;
    assign instr_data  = fifo_head.data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Delivered-instruction count, saturating; flush does not touch it.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    // Delivered-instruction count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    // Delivery counter not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit (ROM_LAT=1, FIFO_DEPTH=4, ROM[a] = a ^ 16'hA5A5).
// A directed vector table covers reset, streaming and backpressure; hand
// sequences cover flush and full-credit push/pop; a random phase is checked
// every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int ROM_LAT = 1;
  localparam int DEPTH   = 4;

  // ---------------- clock / reset signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        instr_valid;
  logic [15:0] instr_addr;
  logic [15:0] instr_data;
  logic        instr_ready;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ROM_LAT    (ROM_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .flush       (flush),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_addr  (instr_addr),
    .instr_data  (instr_data),
    .instr_ready (instr_ready)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // ---------------- ROM model ----------------
  logic [15:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? rom_fn(rom_addr) : 16'hDEAD;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  // ---------------- check bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    int          ret;   // cycle in which the ROM data for this read appears
  } pend_t;

  pend_t       pend_q[$];
  logic [15:0] exp_q[$];   // addresses waiting in the return buffer
  logic [15:0] dlv_q[$];   // every address the consumer took, in order
  logic [15:0] m_cnt = 16'd0;
  logic        cnt_load = 1'b0;

  always @(negedge clk) begin
    bit e_rdy;
    bit e_iv;
    e_rdy = !rst && !flush && ((pend_q.size() + exp_q.size()) < DEPTH);
    e_iv  = !rst && (exp_q.size() != 0);
    if (cnt_load) m_cnt = 16'hFFFE;

    check("m_req_ready", req_ready, e_rdy);
    check("m_rom_en", rom_en, req_valid && e_rdy);
    if (req_valid && e_rdy) check("m_rom_addr", rom_addr, req_addr);
    check("m_instr_valid", instr_valid, e_iv);
    if (e_iv) begin
      check("m_instr_addr", instr_addr, exp_q[0]);
      check("m_instr_data", instr_data, rom_fn(exp_q[0]));
    end
`ifdef FETCH_COUNT_EN
    check("m_fetch_count", fetch_count, m_cnt);
`endif

    // advance the model across the coming rising edge
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      m_cnt = 16'd0;
    end else begin
      if (e_iv && instr_ready) begin
        dlv_q.push_back(exp_q.pop_front());
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (flush) begin
        pend_q.delete();
        exp_q.delete();
      end else begin
        while (pend_q.size() != 0 && pend_q[0].ret == cyc)
          exp_q.push_back(pend_q.pop_front().addr);
        if (req_valid && e_rdy) pend_q.push_back('{addr: req_addr, ret: cyc + ROM_LAT});
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic v, input logic [15:0] a,
                       input logic f, input logic i);
    rst = r; req_valid = v; req_addr = a; flush = f; instr_ready = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] ra;
    logic        fl;
    logic        ir;
    logic        e_rdy;
    logic        e_en;
    logic        e_iv;
    logic [15:0] e_ia;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, v, input logic [15:0] a, input logic f, i,
                              input logic er, ee, ev, input logic [15:0] ea);
    vec_t t;
    t = '{rst: r, rv: v, ra: a, fl: f, ir: i, e_rdy: er, e_en: ee, e_iv: ev, e_ia: ea};
    return t;
  endfunction

  int mark;

  initial begin
    drive(1, 1, 16'h0000, 0, 1);

    // reset held two cycles with a request offered
    vecs.push_back(mk(1, 1, 16'h0000, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0000, 0, 1, 0, 0, 0, 0));
    // streaming 0..7, first instr_valid two cycles after first accept
    vecs.push_back(mk(0, 1, 16'h0000, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0001, 0, 1, 1, 1, 0, 0));
    for (int k = 2; k < 8; k++)
      vecs.push_back(mk(0, 1, 16'(k), 0, 1, 1, 1, 1, 16'(k - 2)));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0006));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0007));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0));
    // backpressure: four accepts then credit runs out
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0001, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0002, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 16'h0003, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 16'h0004, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 16'h0004, 0, 0, 0, 0, 1, 0));
    // release consumer: 0..3 drain and credit returns
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 0, 1, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0001));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0002));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h0003));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].rv, vecs[k].ra, vecs[k].fl, vecs[k].ir);
      @(negedge clk);
      check($sformatf("vec%0d_req_ready", k), req_ready, vecs[k].e_rdy);
      check($sformatf("vec%0d_rom_en", k), rom_en, vecs[k].e_en);
      if (vecs[k].e_en) check($sformatf("vec%0d_rom_addr", k), rom_addr, vecs[k].ra);
      check($sformatf("vec%0d_instr_valid", k), instr_valid, vecs[k].e_iv);
      if (vecs[k].e_iv) begin
        check($sformatf("vec%0d_instr_addr", k), instr_addr, vecs[k].e_ia);
        check($sformatf("vec%0d_instr_data", k), instr_data, rom_fn(vecs[k].e_ia));
      end
      @(posedge clk);
      #1;
    end

    // flush on the cycle 0x0011 data returns; only 0x0100 may ever be delivered
    mark = dlv_q.size();
    drive(0, 1, 16'h0010, 0, 0); tick();
    drive(0, 1, 16'h0011, 0, 0); tick();
    drive(0, 0, 16'h0000, 1, 0);
    @(negedge clk);
    check("flush_req_ready", req_ready, 1'b0);
    tick();
    drive(0, 0, 16'h0000, 0, 1);
    @(negedge clk);
    check("flush_instr_valid_after", instr_valid, 1'b0);
    tick();
    drive(0, 1, 16'h0100, 0, 1); tick();
    drive(0, 0, 16'h0000, 0, 1);
    repeat (5) tick();
    check("flush_deliver_count", dlv_q.size() - mark, 1);
    if (dlv_q.size() > mark) check("flush_deliver_addr", dlv_q[mark], 16'h0100);

    // FIFO 3/4 plus one in flight, then push and pop in the same cycle
    mark = dlv_q.size();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 16'h0200 + 16'(k), 0, 0);
      tick();
    end
    drive(0, 1, 16'h0204, 0, 1);
    @(negedge clk);
    check("full_req_ready", req_ready, 1'b0);
    check("full_head", instr_addr, 16'h0200);
    tick();
    @(negedge clk);
    check("full_req_ready_back", req_ready, 1'b1);
    check("full_head_next", instr_addr, 16'h0201);
    tick();
    drive(0, 0, 16'h0000, 0, 1);
    repeat (6) tick();
    check("full_deliver_count", dlv_q.size() - mark, 5);
    for (int k = 0; k < 5; k++)
      if (mark + k < dlv_q.size())
        check($sformatf("full_order%0d", k), dlv_q[mark + k], 16'h0200 + 16'(k));

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            16'($urandom),
            $urandom_range(0, 39) == 0,
            ((n / 400) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      tick();
    end
    drive(0, 0, 16'h0000, 0, 1);
    repeat (8) tick();

`ifdef FETCH_COUNT_EN
    // preload near saturation, then saturate, then flush and reset
    drive(0, 0, 16'h0000, 0, 0);
    force dut.fetch_count_q = 16'hFFFE;
    cnt_load = 1'b1;
    @(negedge clk);
    #1;
    release dut.fetch_count_q;
    cnt_load = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 16'h0300 + 16'(k), 0, 1);
      tick();
    end
    drive(0, 0, 16'h0000, 0, 1);
    repeat (5) tick();
    @(negedge clk);
    check("cnt_saturated", fetch_count, 16'hFFFF);
    tick();
    drive(0, 0, 16'h0000, 1, 1); tick();
    drive(0, 0, 16'h0000, 0, 1);
    @(negedge clk);
    check("cnt_after_flush", fetch_count, 16'hFFFF);
    tick();
    drive(1, 0, 16'h0000, 0, 1); tick();
    drive(0, 0, 16'h0000, 0, 1);
    @(negedge clk);
    check("cnt_after_rst", fetch_count, 16'h0000);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
